irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt concentrator on the receiving end of peripheral IRQ lines, such as timer/counter IRQ outputs and the external interrupt.
- Latches each source as level or edge, applies a mask, and drives HWInt into CP0.
- Exposes its registers on the same word-addressed bridge interface as the timers: Addr[31:2], WE, Din, Dout.

Parameters:
- N_SRC, 6, number of interrupt sources; drives HWInt width (HWInt[7:2] in CP0).
- BASE, 32'h0000_7F20, byte base address; block decodes 16 bytes (4 words).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  30 [31:2]  word address from bridge.
- WE  input  1  write enable, valid only when the address hits.
- Din  input  32  write data.
- Dout  output  32  read data (combinational).
- irq_in  input  N_SRC  raw interrupt requests; bit 0 = highest priority.
- HWInt  output  N_SRC  PEND & MASK, to CP0.
- irq_out  output  1  OR-reduction of HWInt.

Behaviour:
- Hit: Addr[31:4] == BASE[31:4]. Register index = Addr[3:2].
  - 0 PEND: read; write-1-to-clear, edge-mode bits only.
  - 1 MASK: read/write.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 ACTIVE: read-only; bit31 = any HWInt, bits[4:0] = lowest set HWInt index, other bits 0.
- Registers are N_SRC bits wide, zero-extended on read. Din upper bits are ignored on write.
- Reset (async): PEND = 0, MASK = 0, MODE = 0, irq_prev = 0. So HWInt = 0, irq_out = 0, and Dout at any hit = 0.
- Sample point s = irq_in, or synchronized irq_in (see Optional Feature). irq_prev <= s every cycle.
- Level bit i: PEND[i] <= s[i] every cycle. Writes to PEND have no effect on level bits.
- Edge bit i: PEND[i] is set on s[i] & ~irq_prev[i]. It holds until cleared by writing 1 to that bit of PEND.
  - Set and clear on the same edge: set wins, bit stays 1.
- Latency: s high before edge k puts PEND, HWInt and irq_out high after edge k (1 cycle). HWInt and irq_out are combinational from the registers.
- MASK write at edge k takes effect on HWInt after edge k. Masked sources still latch into PEND.
- MODE change:
  - PEND is not cleared.
  - Edge→level: the bit follows s from the next edge.
  - Level→edge: the current PEND value is held until an edge or a clear.
- Writes to index 3, or with no hit, are ignored.
- Dout = 0 when there is no hit. Reads have no side effects.
- Reset mid-operation clears all state immediately. A source held high across reset release:
  - Level mode: seen on the first edge.
  - Edge mode: seen as a rising edge on the first edge, since irq_prev = 0.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - irq_in passes through a two-flop synchronizer per bit (reset to 0) before becoming s.
  - Input-to-HWInt latency = 3 cycles.
  - A pulse shorter than one clock may be lost.
- Undefined:
  - s = irq_in directly; latency 1 cycle.
  - irq_in must be synchronous to clk.

Test Plan:
1. Reset, then MASK=6'h3F, MODE=0; drive irq_in=6'b000100 → HWInt=6'b000100 one cycle later. ACTIVE read = 32'h8000_0002. Drop irq_in → HWInt=0 next cycle.
2. MODE=6'b000001, MASK=6'h01; pulse irq_in[0] one cycle → PEND stays 1 after pulse ends. Write PEND=32'h1 → PEND=0, irq_out=0.
3. Edge source 0: new rising edge on the same cycle as a PEND write-1 → PEND[0] remains 1.
4. MASK=0, irq_in=6'b100001 → PEND=6'b100001, HWInt=0. Then MASK=6'h20 → HWInt=6'b100000, ACTIVE=32'h8000_0005.
5. Address outside BASE..BASE+15 with WE=1, Din=32'hFFFF_FFFF → MASK/MODE unchanged, Dout=0. Assert reset mid-run → all registers read 0 without a clock edge.
6. With IRQ_SYNC_EN defined: irq_in[3] rises → HWInt[3] rises exactly 3 edges later.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt concentrator: per-source level/edge latch, mask, and a 4-word register window on the bridge bus.
// Optional IRQ_SYNC_EN inserts a two-flop synchronizer on irq_in (3-cycle input-to-HWInt latency).
module irq_ctrl #(
  parameter int          N_SRC = 6,
  parameter logic [31:0] BASE  = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] HWInt,
  output logic             irq_out
);

  logic [N_SRC-1:0] r_pend, r_mask, r_mode, r_prev;
  logic [N_SRC-1:0] w_s, w_rise, w_clr, w_pend_nxt;
  logic             w_hit, w_wr;
  logic [1:0]       w_idx;
  logic [4:0]       w_low;
  logic             w_unused;

  assign w_hit    = (Addr[31:4] == BASE[31:4]);
  assign w_idx    = Addr[3:2];
  assign w_wr     = w_hit & WE;
  assign w_unused = ^Din;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = irq_in;
`endif

  // Clear only affects edge bits; a rising edge on the same cycle wins over the clear.
  assign w_clr      = (w_wr && w_idx == 2'd0) ? Din[N_SRC-1:0] : '0;
  assign w_rise     = w_s & ~r_prev;
  assign w_pend_nxt = (r_mode & ((r_pend & ~w_clr) | w_rise)) | (~r_mode & w_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
      r_prev <= '0;
    end else begin
      r_prev <= w_s;
      r_pend <= w_pend_nxt;
      if (w_wr && w_idx == 2'd1) r_mask <= Din[N_SRC-1:0];
      if (w_wr && w_idx == 2'd2) r_mode <= Din[N_SRC-1:0];
    end
  end

  assign HWInt   = r_pend & r_mask;
  assign irq_out = |HWInt;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    w_low = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (HWInt[i]) w_low = 5'(i);
  end

  always_comb begin
    Dout = '0;
    if (w_hit) begin
      case (w_idx)
        2'd0: Dout[N_SRC-1:0] = r_pend;
        2'd1: Dout[N_SRC-1:0] = r_mask;
        2'd2: Dout[N_SRC-1:0] = r_mode;
        default: Dout = {irq_out, 26'd0, w_low};
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected values are queued at stimulus time and popped at each check.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [29:0] A0 = 30'(32'h0000_7F20 >> 2);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic [5:0]  irq_in = '0;
  logic [5:0]  HWInt;
  logic        irq_out;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  irq_ctrl #(.N_SRC(6), .BASE(32'h0000_7F20)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
    .irq_in(irq_in), .HWInt(HWInt), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sb(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    Addr = A0 + 30'(idx);
    WE   = 1'b1;
    Din  = d;
    tick();
    WE   = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    Addr = A0 + 30'(idx);
    WE   = 1'b0;
    #1;
    d = Dout;
  endtask

  initial begin
    logic [31:0] v;

    // Reset state
    tick(2);
    sb(0); sb(0); sb(0); sb(0); sb(0); sb(0);
    rd(0, v); chk("rst_pend", v);
    rd(1, v); chk("rst_mask", v);
    rd(2, v); chk("rst_mode", v);
    rd(3, v); chk("rst_active", v);
    chk("rst_hwint", 32'(HWInt));
    chk("rst_irqout", 32'(irq_out));
    @(posedge clk); #1 reset = 1'b0;

    // 1: level source 2
    wr(1, 32'h3F); wr(2, 32'h0);
    irq_in = 6'b000100;
    sb(32'h04); sb(1); sb(32'h8000_0002);
    tick(LAT);
    chk("lvl_hwint", 32'(HWInt));
    chk("lvl_irqout", 32'(irq_out));
    rd(3, v); chk("lvl_active", v);
    irq_in = '0;
    sb(0);
    tick(LAT);
    chk("lvl_drop", 32'(HWInt));

    // 2: edge source 0 latches a one-cycle pulse, W1C clears it
    wr(2, 32'h1); wr(1, 32'h1);
    irq_in = 6'b000001; tick();
    irq_in = '0;        tick(LAT);
    sb(1); sb(1);
    rd(0, v); chk("edge_hold_pend", v);
    chk("edge_hold_hwint", 32'(HWInt));
    wr(0, 32'h1);
    sb(0); sb(0);
    rd(0, v); chk("edge_clr_pend", v);
    chk("edge_clr_irqout", 32'(irq_out));

    // 3: rising edge coincides with a W1C: set wins
    irq_in = 6'b000001;
    tick(LAT - 1);
    wr(0, 32'h1);
    sb(1);
    rd(0, v); chk("set_wins", v);
    irq_in = '0; tick(LAT);
    wr(0, 32'h1);
    sb(0);
    rd(0, v); chk("clr_after", v);

    // 4: masked sources still latch
    wr(2, 32'h0); wr(1, 32'h0);
    irq_in = 6'b100001; tick(LAT);
    sb(32'h21); sb(0); sb(0);
    rd(0, v); chk("masked_pend", v);
    chk("masked_hwint", 32'(HWInt));
    chk("masked_irqout", 32'(irq_out));
    wr(1, 32'h20);
    sb(32'h20); sb(32'h8000_0005);
    chk("mask20_hwint", 32'(HWInt));
    rd(3, v); chk("mask20_active", v);
    // level->edge holds PEND; edge->level follows s
    wr(2, 32'h20);
    irq_in = '0; tick(LAT);
    sb(32'h20);
    rd(0, v); chk("l2e_hold", v);
    wr(2, 32'h0); tick(LAT);
    sb(0);
    rd(0, v); chk("e2l_follow", v);

    // 6: exact latency on source 3
    wr(1, 32'h3F);
    irq_in = 6'b001000;
    for (int k = 0; k < LAT - 1; k++) begin
      tick();
      sb(0);
      chk("lat_early", 32'(HWInt));
    end
    tick();
    sb(32'h08);
    chk("lat_exact", 32'(HWInt));

    // 5: misses, read-only ACTIVE, upper Din bits
    wr(1, 32'h15); wr(2, 32'h0A);
    Addr = A0 + 30'd4; WE = 1'b1; Din = 32'hFFFF_FFFF; tick(); WE = 1'b0;
    Addr = A0 - 30'd1; WE = 1'b1; tick(); WE = 1'b0;
    wr(3, 32'hFFFF_FFFF);
    sb(32'h15); sb(32'h0A); sb(0); sb(0);
    rd(1, v); chk("miss_mask", v);
    rd(2, v); chk("miss_mode", v);
    Addr = A0 + 30'd4; #1; chk("miss_dout_hi", Dout);
    Addr = A0 - 30'd1; #1; chk("miss_dout_lo", Dout);
    wr(1, 32'hFFFF_FFC0);
    sb(0);
    rd(1, v); chk("din_upper", v);

    // Reset mid-run, no clock edge
    wr(1, 32'h3F); wr(2, 32'h0);
    irq_in = 6'b100001; tick(LAT);
    sb(32'h21);
    chk("pre_rst_hwint", 32'(HWInt));
    #1 reset = 1'b1; #1;
    sb(0); sb(0); sb(0); sb(0); sb(0);
    chk("async_hwint", 32'(HWInt));
    chk("async_irqout", 32'(irq_out));
    rd(0, v); chk("async_pend", v);
    rd(1, v); chk("async_mask", v);
    rd(2, v); chk("async_mode", v);
    @(posedge clk); #1 reset = 1'b0;
    // source held across release is seen as soon as it reaches s
    wr(1, 32'h3F);
    tick(LAT - 1);
    sb(32'h21);
    rd(0, v); chk("post_rst_pend", v);

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
